fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: sequential instruction fetch from a synchronous-strobe ROM.
// Holds the PC, drives the ROM strobes for (ROM_WAIT+1) cycles per word and
// buffers fetched words for a valid/ready consumer. Redirects flush and restart.
// Build option: define FETCH_PREFETCH_EN for a 2-entry prefetch FIFO in place
// of the single output register.
module fetch_sequencer #(
    parameter int unsigned ROM_WAIT = 0,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] rom_address,
    output logic        rom_chip_select,
    output logic        rom_output_enable,
    input  logic [63:0] rom_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    output logic        align_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    localparam bit         NO_WAIT   = (ROM_WAIT == 0);
    localparam logic [2:0] WAIT_LAST = 3'((ROM_WAIT == 0) ? 0 : ROM_WAIT - 1);

    state_t      r_state;
    logic [31:0] r_pc;
    logic [2:0]  r_wait_left;
    logic        r_align_err;

    logic        w_slot_free;
    logic        w_xfer;
    logic        w_issue_ok;
    logic        w_access;
    logic        w_capture;
    logic [31:0] w_word;
    logic        w_unused_rom_hi;

    assign w_word          = rom_data[31:0];
    assign w_unused_rom_hi = ^rom_data[63:32];

    // Access/capture decisions; the strobes depend on this cycle's instr_ready so
    // that a slot freed by a transfer can be refilled without a bubble.
    always_comb begin
        w_xfer     = instr_valid && instr_ready;
        w_issue_ok = !halt && (w_slot_free || w_xfer);
        w_access   = ((r_state == S_ISSUE) && w_issue_ok) || (r_state == S_WAIT);
        w_capture  = !redirect &&
                     (((r_state == S_ISSUE) && w_issue_ok && NO_WAIT) ||
                      ((r_state == S_WAIT) && (r_wait_left == 3'd0)));
    end

    assign rom_address       = r_pc;
    assign rom_chip_select   = w_access;
    assign rom_output_enable = w_access;
    assign align_err         = r_align_err;

    // Fetch FSM: PC, wait counter and sticky alignment flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_wait_left <= '0;
            r_align_err <= 1'b0;
        end else begin
            if (redirect && (redirect_target[1:0] != 2'b00)) begin
                r_align_err <= 1'b1;
            end
            if (redirect) begin
                r_state     <= S_ISSUE;
                r_pc        <= {redirect_target[31:2], 2'b00};
                r_wait_left <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ISSUE;
                    end
                    S_ISSUE: begin
                        if (w_issue_ok) begin
                            if (NO_WAIT) begin
                                r_pc <= r_pc + 32'd4;
                            end else begin
                                r_state     <= S_WAIT;
                                r_wait_left <= WAIT_LAST;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (r_wait_left == 3'd0) begin
                            r_state <= S_ISSUE;
                            r_pc    <= r_pc + 32'd4;
                        end else begin
                            r_wait_left <= r_wait_left - 3'd1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FETCH_PREFETCH_EN
    logic [1:0]  r_count;
    logic [31:0] r_ins [2];
    logic [31:0] r_ipc [2];

    assign w_slot_free = (r_count != 2'd2);
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_ins[0];
    assign instr_pc    = r_ipc[0];

    // Two-entry FIFO, head always in slot 0; a pop shifts slot 1 down.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count  <= '0;
            r_ins[0] <= '0;
            r_ins[1] <= '0;
            r_ipc[0] <= '0;
            r_ipc[1] <= '0;
        end else if (redirect) begin
            r_count <= '0;
        end else begin
            case ({w_capture, w_xfer})
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_ins[0] <= w_word;
                        r_ipc[0] <= r_pc;
                    end else begin
                        r_ins[0] <= r_ins[1];
                        r_ipc[0] <= r_ipc[1];
                        r_ins[1] <= w_word;
                        r_ipc[1] <= r_pc;
                    end
                end
                2'b10: begin
                    r_ins[r_count[0]] <= w_word;
                    r_ipc[r_count[0]] <= r_pc;
                    r_count           <= r_count + 2'd1;
                end
                2'b01: begin
                    r_ins[0] <= r_ins[1];
                    r_ipc[0] <= r_ipc[1];
                    r_count  <= r_count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end
`else
    logic        r_valid;
    logic [31:0] r_ins;
    logic [31:0] r_ipc;

    assign w_slot_free = !r_valid;
    assign instr_valid = r_valid;
    assign instr       = r_ins;
    assign instr_pc    = r_ipc;

    // Single output register; a capture may land in the same cycle as a transfer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_ins   <= '0;
            r_ipc   <= '0;
        end else if (redirect) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_ins   <= w_word;
            r_ipc   <= r_pc;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: two instances (ROM_WAIT=0 and 2)
// share stimulus; directed scenarios plus a randomized run against a
// transaction-level model (PC, buffered-entry list, access-cycle count).
module tb_fetch_sequencer;

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic        redirect;
    logic        halt;
    logic [31:0] target;

    logic [31:0] addr0, addr2, ins0, ins2, ipc0, ipc2;
    logic        cs0, oe0, cs2, oe2, v0, v2, ae0, ae2;
    logic [63:0] rd0, rd2;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign rd0 = {~addr0, rom_word(addr0)};
    assign rd2 = {~addr2, rom_word(addr2)};

    fetch_sequencer #(.ROM_WAIT(0), .RESET_PC(32'h0000_0000)) u_dut0 (
        .clock(clock), .reset(reset),
        .rom_address(addr0), .rom_chip_select(cs0), .rom_output_enable(oe0),
        .rom_data(rd0),
        .instr(ins0), .instr_pc(ipc0), .instr_valid(v0), .instr_ready(ready),
        .redirect(redirect), .redirect_target(target), .halt(halt),
        .align_err(ae0)
    );

    fetch_sequencer #(.ROM_WAIT(2), .RESET_PC(32'h0000_0000)) u_dut2 (
        .clock(clock), .reset(reset),
        .rom_address(addr2), .rom_chip_select(cs2), .rom_output_enable(oe2),
        .rom_data(rd2),
        .instr(ins2), .instr_pc(ipc2), .instr_valid(v2), .instr_ready(ready),
        .redirect(redirect), .redirect_target(target), .halt(halt),
        .align_err(ae2)
    );

    // ---------------- reference model (index 0: ROM_WAIT=0, 1: ROM_WAIT=2)
    int          m_started [2];
    int          m_busy    [2];
    int          m_cnt     [2];
    logic [31:0] m_pc      [2];
    logic [31:0] m_bpc     [2][2];
    logic [31:0] m_bins    [2][2];
    logic        m_align   [2];

    function automatic int waits_of(input int i);
        return (i == 0) ? 0 : 2;
    endfunction

    // A word is being fetched when an access is in progress, or when fetching
    // is allowed and the buffer has (or is about to have) room.
    function automatic logic exp_strobe(input int i);
        return (m_started[i] != 0) &&
               (m_busy[i] > 0 ||
                (!halt && (m_cnt[i] < DEPTH || (m_cnt[i] > 0 && ready))));
    endfunction

    always @(posedge clock) begin
        for (int i = 0; i < 2; i++) begin
            logic st, dl;
            if (reset) begin
                m_started[i] = 0; m_busy[i] = 0; m_cnt[i] = 0;
                m_pc[i] = 32'h0; m_align[i] = 1'b0;
            end else begin
                st = exp_strobe(i);
                dl = (m_cnt[i] > 0) && ready;
                if (redirect) begin
                    if (target[1:0] != 2'b00) m_align[i] = 1'b1;
                    m_cnt[i]  = 0;
                    m_busy[i] = 0;
                    m_pc[i]   = {target[31:2], 2'b00};
                end else begin
                    if (dl) begin
                        m_bpc[i][0]  = m_bpc[i][1];
                        m_bins[i][0] = m_bins[i][1];
                        m_cnt[i]     = m_cnt[i] - 1;
                    end
                    if (st) begin
                        m_busy[i] = m_busy[i] + 1;
                        if (m_busy[i] == waits_of(i) + 1) begin
                            m_bpc[i][m_cnt[i]]  = m_pc[i];
                            m_bins[i][m_cnt[i]] = rom_word(m_pc[i]);
                            m_cnt[i]  = m_cnt[i] + 1;
                            m_pc[i]   = m_pc[i] + 32'd4;
                            m_busy[i] = 0;
                        end
                    end
                end
                m_started[i] = 1;
            end
        end
    end

    // Two reset cycles; returns at the falling edge right after release.
    task automatic do_reset;
        reset = 1'b1; ready = 1'b1; halt = 1'b0; redirect = 1'b0; target = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; ready = 1'b1; halt = 1'b0; redirect = 1'b0; target = '0;
        repeat (2) @(negedge clock);
        #1;
        checks++; if (addr0 !== 32'h0) begin errors++; $display("FAIL reset_addr0: got %h expected %h", addr0, 32'h0); end
        checks++; if ({cs0, oe0, cs2, oe2} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {cs0, oe0, cs2, oe2}); end
        checks++; if ({v0, v2} !== 2'b0) begin errors++; $display("FAIL reset_valid: got %b expected 00", {v0, v2}); end
        checks++; if (ins0 !== 32'h0 || ipc0 !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h/%h expected 0/0", ins0, ipc0); end
        checks++; if ({ae0, ae2} !== 2'b0) begin errors++; $display("FAIL reset_align: got %b expected 00", {ae0, ae2}); end
    endtask

    task automatic test_latency;
        do_reset();
        #1;
        checks++; if (cs0 !== 1'b0) begin errors++; $display("FAIL lat_idle_cs: got %b expected 0", cs0); end
        @(negedge clock); #1;
        checks++; if (cs0 !== 1'b1 || oe0 !== 1'b1 || addr0 !== 32'h0) begin errors++; $display("FAIL lat_issue: got cs=%b oe=%b a=%h expected 1 1 0", cs0, oe0, addr0); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b expected 0", v0); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            checks++; if (v0 !== 1'b1 || ipc0 !== 32'(4 * k)) begin errors++; $display("FAIL lat_seq[%0d]: got v=%b pc=%h expected 1 %h", k, v0, ipc0, 32'(4 * k)); end
            checks++; if (ins0 !== rom_word(32'(4 * k))) begin errors++; $display("FAIL lat_instr[%0d]: got %h expected %h", k, ins0, rom_word(32'(4 * k))); end
        end
    endtask

    task automatic test_rom_wait;
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            logic        ev;
            logic [31:0] ea;
            @(negedge clock); #1;
            ea = 32'(4 * ((k - 1) / 3));
            ev = (k >= 4) && ((k - 4) % 3 == 0);
            checks++; if (cs2 !== 1'b1 || oe2 !== 1'b1) begin errors++; $display("FAIL wait_strobe[%0d]: got %b%b expected 11", k, cs2, oe2); end
            checks++; if (addr2 !== ea) begin errors++; $display("FAIL wait_addr[%0d]: got %h expected %h", k, addr2, ea); end
            checks++; if (v2 !== ev) begin errors++; $display("FAIL wait_valid[%0d]: got %b expected %b", k, v2, ev); end
            if (ev) begin
                checks++; if (ipc2 !== 32'(4 * ((k - 4) / 3))) begin errors++; $display("FAIL wait_pc[%0d]: got %h expected %h", k, ipc2, 32'(4 * ((k - 4) / 3))); end
            end
        end
    endtask

    task automatic test_stall;
        do_reset();
        ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock); #1;
            if (k >= 3) begin
                checks++; if (v0 !== 1'b1 || ipc0 !== 32'h0 || ins0 !== rom_word(32'h0)) begin errors++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h expected 1 0", k, v0, ipc0); end
                checks++; if (cs0 !== 1'b0 || oe0 !== 1'b0) begin errors++; $display("FAIL stall_strobe[%0d]: got %b%b expected 00", k, cs0, oe0); end
                checks++; if (addr0 !== 32'(4 * DEPTH)) begin errors++; $display("FAIL stall_addr[%0d]: got %h expected %h", k, addr0, 32'(4 * DEPTH)); end
            end
        end
        ready = 1'b1;
        #1;
        checks++; if (cs0 !== 1'b1) begin errors++; $display("FAIL stall_refill_cs: got %b expected 1", cs0); end
        for (int j = 1; j <= 3; j++) begin
            @(negedge clock); #1;
            checks++; if (v0 !== 1'b1 || ipc0 !== 32'(4 * j)) begin errors++; $display("FAIL stall_drain[%0d]: got v=%b pc=%h expected 1 %h", j, v0, ipc0, 32'(4 * j)); end
        end
    endtask

    task automatic test_redirect;
        do_reset();
        repeat (2) @(negedge clock);
        #1;
        checks++; if (v0 !== 1'b1 || ipc0 !== 32'h0) begin errors++; $display("FAIL redir_pre: got v=%b pc=%h expected 1 0", v0, ipc0); end
        redirect = 1'b1; target = 32'h30;
        @(negedge clock);
        redirect = 1'b0;
        #1;
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL redir_flush: got %b expected 0", v0); end
        checks++; if (addr0 !== 32'h30 || cs0 !== 1'b1) begin errors++; $display("FAIL redir_issue: got a=%h cs=%b expected 30 1", addr0, cs0); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); #1;
            checks++; if (v0 !== 1'b1 || ipc0 !== 32'(32'h30 + 4 * k)) begin errors++; $display("FAIL redir_seq[%0d]: got v=%b pc=%h expected 1 %h", k, v0, ipc0, 32'(32'h30 + 4 * k)); end
        end
        checks++; if (ae0 !== 1'b0) begin errors++; $display("FAIL redir_align: got %b expected 0", ae0); end
    endtask

    task automatic test_align;
        do_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++; if (ae0 !== 1'b0) begin errors++; $display("FAIL align_pre: got %b expected 0", ae0); end
        redirect = 1'b1; target = 32'h31;
        @(negedge clock);
        redirect = 1'b0;
        #1;
        checks++; if (ae0 !== 1'b1 || ae2 !== 1'b1) begin errors++; $display("FAIL align_set: got %b%b expected 11", ae0, ae2); end
        checks++; if (addr0 !== 32'h30 || v0 !== 1'b0) begin errors++; $display("FAIL align_addr: got a=%h v=%b expected 30 0", addr0, v0); end
        @(negedge clock); #1;
        checks++; if (v0 !== 1'b1 || ipc0 !== 32'h30) begin errors++; $display("FAIL align_fetch: got v=%b pc=%h expected 1 30", v0, ipc0); end
        repeat (4) @(negedge clock);
        #1;
        checks++; if (ae0 !== 1'b1) begin errors++; $display("FAIL align_sticky: got %b expected 1", ae0); end
        reset = 1'b1;
        @(negedge clock); #1;
        checks++; if (ae0 !== 1'b0 || ae2 !== 1'b0) begin errors++; $display("FAIL align_clear: got %b%b expected 00", ae0, ae2); end
    endtask

    task automatic test_wrap;
        do_reset();
        @(negedge clock);
        redirect = 1'b1; target = 32'hFFFF_FFF8;
        @(negedge clock);
        redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            logic [31:0] ep;
            ep = 32'hFFFF_FFF8 + 32'(4 * k);
            @(negedge clock); #1;
            checks++; if (v0 !== 1'b1 || ipc0 !== ep || ins0 !== rom_word(ep)) begin errors++; $display("FAIL wrap[%0d]: got v=%b pc=%h expected 1 %h", k, v0, ipc0, ep); end
        end
    endtask

    task automatic test_halt;
        do_reset();
        @(negedge clock);
        @(negedge clock);
        halt = 1'b1;
        #1;
        checks++; if (cs2 !== 1'b1) begin errors++; $display("FAIL halt_wait_kept: got %b expected 1", cs2); end
        checks++; if (cs0 !== 1'b0) begin errors++; $display("FAIL halt_issue0: got %b expected 0", cs0); end
        @(negedge clock); #1;
        checks++; if (cs2 !== 1'b1 || addr2 !== 32'h0) begin errors++; $display("FAIL halt_wait2: got cs=%b a=%h expected 1 0", cs2, addr2); end
        @(negedge clock); #1;
        checks++; if (v2 !== 1'b1 || ipc2 !== 32'h0 || cs2 !== 1'b0) begin errors++; $display("FAIL halt_capture: got v=%b pc=%h cs=%b expected 1 0 0", v2, ipc2, cs2); end
        @(negedge clock); #1;
        checks++; if (v2 !== 1'b0 || cs2 !== 1'b0) begin errors++; $display("FAIL halt_drained: got v=%b cs=%b expected 0 0", v2, cs2); end
        halt = 1'b0;
        #1;
        checks++; if (cs2 !== 1'b1 || addr2 !== 32'h4) begin errors++; $display("FAIL halt_resume: got cs=%b a=%h expected 1 4", cs2, addr2); end
    endtask

    task automatic test_random;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] t;
            reset    = ($urandom_range(0, 149) == 0);
            ready    = ($urandom_range(0, 3) != 0);
            halt     = ($urandom_range(0, 6) == 0);
            redirect = ($urandom_range(0, 19) == 0);
            t = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) t[31:8] = 24'hFFFFFF;
            target = t;
            #1;
            for (int i = 0; i < 2; i++) begin
                logic        av, acs, aoe, aae, es;
                logic [31:0] aa, aipc, ains;
                av   = (i == 0) ? v0 : v2;
                acs  = (i == 0) ? cs0 : cs2;
                aoe  = (i == 0) ? oe0 : oe2;
                aae  = (i == 0) ? ae0 : ae2;
                aa   = (i == 0) ? addr0 : addr2;
                aipc = (i == 0) ? ipc0 : ipc2;
                ains = (i == 0) ? ins0 : ins2;
                es   = exp_strobe(i);
                checks++; if (av !== (m_cnt[i] > 0)) begin errors++; $display("FAIL rand_valid[%0d] n=%0d: got %b expected %b", i, n, av, m_cnt[i] > 0); end
                if (m_cnt[i] > 0) begin
                    checks++; if (aipc !== m_bpc[i][0] || ains !== m_bins[i][0]) begin errors++; $display("FAIL rand_head[%0d] n=%0d: got %h/%h expected %h/%h", i, n, aipc, ains, m_bpc[i][0], m_bins[i][0]); end
                end
                checks++; if (acs !== es || aoe !== es) begin errors++; $display("FAIL rand_strobe[%0d] n=%0d: got %b%b expected %b", i, n, acs, aoe, es); end
                checks++; if (aa !== m_pc[i]) begin errors++; $display("FAIL rand_addr[%0d] n=%0d: got %h expected %h", i, n, aa, m_pc[i]); end
                checks++; if (aae !== m_align[i]) begin errors++; $display("FAIL rand_align[%0d] n=%0d: got %b expected %b", i, n, aae, m_align[i]); end
            end
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1; ready = 1'b1; halt = 1'b0; redirect = 1'b0; target = '0;
        test_reset();
        test_latency();
        test_rom_wait();
        test_stall();
        test_redirect();
        test_align();
        test_wrap();
        test_halt();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
